// File: rtl/lcd_hd44780_ctrl_pkg.sv
// Shared types and constants for the HD44780 character-LCD write driver.
package lcd_pkg;

  // Controller phases, in the order a single write walks through them.
  typedef enum logic [2:0] {
    ST_POWERUP = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SETUP   = 3'd2,
    ST_PULSE   = 3'd3,
    ST_HOLD    = 3'd4,
    ST_WAIT    = 3'd5,
    ST_IDLE    = 3'd6
  } lcd_state_e;

  // HD44780 instruction bytes used by the driver.
  localparam logic [7:0] CMD_CLEAR   = 8'h01;
  localparam logic [7:0] CMD_HOME    = 8'h02;
  localparam logic [7:0] CMD_FUNC    = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] CMD_DISP_ON = 8'h0C;  // display on, cursor off
  localparam logic [7:0] CMD_ENTRY   = 8'h06;  // increment, no shift

  // Power-on init sequence, issued in order before any request is accepted.
  localparam int INIT_LEN = 6;
  localparam logic [7:0] INIT_ROM [INIT_LEN] = '{
    CMD_FUNC, CMD_FUNC, CMD_FUNC, CMD_DISP_ON, CMD_CLEAR, CMD_ENTRY
  };
  localparam logic [2:0] INIT_LAST = 3'(INIT_LEN - 1);

  // Table lookup that stays in range for every value of a 3-bit index.
  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    init_cmd = 8'h00;
    for (int i = 0; i < INIT_LEN; i++) begin
      if (idx == 3'(i)) init_cmd = INIT_ROM[i];
    end
  endfunction

  // Clear and return-home are the only slow instructions.
  function automatic logic is_slow_cmd(input logic rs, input logic [7:0] d);
    return !rs && ((d == CMD_CLEAR) || (d == CMD_HOME));
  endfunction

endpackage

// File: rtl/lcd_hd44780_ctrl_delay_cnt.sv
// Loadable down-counter that times every LCD phase. It sits at zero once
// expired, so the zero flag doubles as "phase finished".
module lcd_delay_cnt #(
  parameter int           W       = 20,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] cnt_q;

  // Load on request, otherwise count down and stop at zero.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      cnt_q <= RST_VAL;
    end else if (i_load) begin
      cnt_q <= i_load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign o_zero = (cnt_q == '0);

endmodule

// File: rtl/lcd_hd44780_ctrl.sv
// Write-only HD44780 driver: runs the power-on init sequence, then takes one
// RS+byte per valid/ready handshake and produces setup / E pulse / hold /
// execution-wait timing on the LCD pins. All outputs come from registers.
module lcd_hd44780_ctrl
  import lcd_pkg::*;
#(
  parameter int T_POWERUP = 750000,
  parameter int T_SETUP   = 4,
  parameter int T_EN      = 12,
  parameter int T_HOLD    = 4,
  parameter int T_CMD     = 2000,
  parameter int T_CLEAR   = 82000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_valid,
  input  logic       i_rs,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_init_done,
  output logic [7:0] o_lcd_data,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic       o_lcd_en,
  output logic       o_lcd_on
);

  localparam int T_MAX_A = (T_POWERUP > T_CLEAR) ? T_POWERUP : T_CLEAR;
  localparam int T_MAX_B = (T_CMD > T_EN) ? T_CMD : T_EN;
  localparam int T_MAX_C = (T_SETUP > T_HOLD) ? T_SETUP : T_HOLD;
  localparam int T_MAX_D = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int T_MAX   = (T_MAX_D > T_MAX_C) ? T_MAX_D : T_MAX_C;
  localparam int CNT_W   = $clog2(T_MAX + 1);

  lcd_state_e  state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic        done_q, done_d;
  logic        rs_q, rs_d;
  logic [7:0]  data_q, data_d;
  logic        en_q, ready_q, on_q;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_zero;
  logic             long_wait;

  lcd_delay_cnt #(
    .W       (CNT_W),
    .RST_VAL (CNT_W'(T_POWERUP - 1))
  ) u_delay (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (cnt_load),
    .i_load_val (cnt_load_val),
    .o_zero     (cnt_zero)
  );

  // The first init step gets the long wait as well: the controller may still
  // be settling its interface width after power-up.
  assign long_wait = is_slow_cmd(rs_q, data_q) || (!done_q && (idx_q == 3'd0));

  // Next-state, counter reload and latched pin values.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    done_d       = done_q;
    rs_d         = rs_q;
    data_d       = data_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    unique case (state_q)
      ST_POWERUP: begin
        if (cnt_zero) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        rs_d         = 1'b0;
        data_d       = init_cmd(idx_q);
        state_d      = ST_SETUP;
        cnt_load     = 1'b1;
        cnt_load_val = CNT_W'(T_SETUP - 1);
      end
      ST_SETUP: begin
        if (cnt_zero) begin
          state_d      = ST_PULSE;
          cnt_load     = 1'b1;
          cnt_load_val = CNT_W'(T_EN - 1);
        end
      end
      ST_PULSE: begin
        if (cnt_zero) begin
          state_d      = ST_HOLD;
          cnt_load     = 1'b1;
          cnt_load_val = CNT_W'(T_HOLD - 1);
        end
      end
      ST_HOLD: begin
        if (cnt_zero) begin
          state_d      = ST_WAIT;
          cnt_load     = 1'b1;
          cnt_load_val = long_wait ? CNT_W'(T_CLEAR - 1) : CNT_W'(T_CMD - 1);
        end
      end
      ST_WAIT: begin
        if (cnt_zero) begin
          if (!done_q && (idx_q < INIT_LAST)) begin
            idx_d   = idx_q + 3'd1;
            state_d = ST_LOAD;
          end else begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_IDLE: begin
        if (i_valid) begin
          rs_d         = i_rs;
          data_d       = i_data;
          state_d      = ST_SETUP;
          cnt_load     = 1'b1;
          cnt_load_val = CNT_W'(T_SETUP - 1);
        end
      end
      default: state_d = ST_POWERUP;
    endcase
  end

  // State, pin and status registers; EN and ready follow the next state so
  // they line up exactly with PULSE and IDLE.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_POWERUP;
      idx_q   <= 3'd0;
      done_q  <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      en_q    <= 1'b0;
      ready_q <= 1'b0;
      on_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      en_q    <= (state_d == ST_PULSE);
      ready_q <= (state_d == ST_IDLE);
      on_q    <= 1'b1;
    end
  end

  assign o_ready     = ready_q;
  assign o_init_done = done_q;
  assign o_lcd_data  = data_q;
  assign o_lcd_rs    = rs_q;
  assign o_lcd_rw    = 1'b0;
  assign o_lcd_en    = en_q;
  assign o_lcd_on    = on_q;

endmodule

// File: doc/lcd_hd44780_ctrl.md
Name: lcd_hd44780_ctrl

Overview:
- Write-only HD44780-style character-LCD driver on the output side of the IO path (consumes what writeback commits to the LCD IO register).
- Accepts one byte at a time (RS + data) over a valid/ready handshake.
- Generates setup, enable-pulse, hold and execution-delay timing on the LCD pins.
- Runs a fixed power-on init sequence before it accepts any request.

Parameters:
- T_POWERUP, 750000, cycles to wait after reset before the first init command (15 ms @ 50 MHz).
- T_SETUP, 4, cycles RS/data are stable before EN rises.
- T_EN, 12, cycles EN is held high.
- T_HOLD, 4, cycles RS/data are held after EN falls.
- T_CMD, 2000, execution wait for a normal command or data write (40 us).
- T_CLEAR, 82000, execution wait for clear/home and for init step 0 (1.64 ms).

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  asynchronous active-low reset.
- i_valid  in  1  request valid.
- i_rs  in  1  register select (0 = command, 1 = data).
- i_data  in  8  byte to write.
- o_ready  out  1  block idle and accepting.
- o_init_done  out  1  init sequence complete (sticky until reset).
- o_lcd_data  out  8  LCD DB[7:0].
- o_lcd_rs  out  1  LCD RS.
- o_lcd_rw  out  1  LCD RW (always 0).
- o_lcd_en  out  1  LCD E.
- o_lcd_on  out  1  LCD power/backlight enable.

Behaviour:
- Clock and reset: single clock i_clk; i_reset is asynchronous, active-low. All outputs are registered.
- Reset values: o_ready=0, o_init_done=0, o_lcd_data=0, o_lcd_rs=0, o_lcd_rw=0, o_lcd_en=0, o_lcd_on=0. State = POWERUP, counter loaded with T_POWERUP-1, init index = 0.
- o_lcd_on becomes 1 on the first clock edge after reset release and stays 1.
- States: POWERUP, LOAD, SETUP, PULSE, HOLD, WAIT, IDLE.
- Phase timing: every timed phase lasts exactly N cycles for parameter N. The down-counter loads N-1 on phase entry and advances the state when it reads 0. All parameters must be >= 1. Counter width is $clog2(max parameter + 1).
- POWERUP: EN=0. After T_POWERUP cycles -> LOAD.
- LOAD: drives init ROM[index] onto o_lcd_data with RS=0, then -> SETUP. Lasts 1 cycle.
- Init ROM: 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06.
- SETUP: EN=0 for T_SETUP cycles.
- PULSE: EN=1 for T_EN cycles.
- HOLD: EN=0 for T_HOLD cycles.
- RS and data stay constant from SETUP entry until HOLD exit.
- WAIT: EN=0. Length is T_CLEAR if (RS=0 and data is 0x01 or 0x02) or (init index = 0); otherwise T_CMD.
- Exit from WAIT:
  - Init active with index < 5: index++ and -> LOAD.
  - Index = 5: set o_init_done=1 and -> IDLE.
  - Otherwise: -> IDLE.
- IDLE: o_ready=1; no other state drives ready.
- Handshake: transfer occurs when i_valid && o_ready on an edge. On that edge i_rs/i_data are latched into o_lcd_rs/o_lcd_data, o_ready falls and the state becomes SETUP. i_valid/i_data are don't-care while o_ready=0.
- Back-to-back requests: a request held valid through the busy period is accepted exactly once, on the first IDLE cycle.
- Request during init: not accepted (o_ready=0 until init completes).
- Write latency: one write occupies T_SETUP+T_EN+T_HOLD+wait cycles after the accept edge, then 1 IDLE cycle minimum before the next accept.
- Reset mid-operation: EN drops to 0 immediately (asynchronous). o_init_done clears and the full init sequence reruns after release.
- o_lcd_rw is tied to 0 in every state; no busy-flag reads.

Decomposition:
- Package lcd_pkg:
  - state enum (lcd_state_e).
  - init ROM constant array and its length (6).
  - command constants: CMD_CLEAR=0x01, CMD_HOME=0x02, CMD_FUNC=0x38, CMD_DISP_ON=0x0C, CMD_ENTRY=0x06.
- Sub-module lcd_delay_cnt: loadable down-counter with load value, load strobe and zero flag. Instantiated once in the FSM module.

Test Plan (bench parameters T_POWERUP=10, T_SETUP=2, T_EN=3, T_HOLD=2, T_CMD=5, T_CLEAR=20):
1. Release reset -> EN low for 10 cycles. Then 6 EN pulses, each exactly 3 cycles wide, with data 38,38,38,0C,01,06 and RS=0. Gaps after pulses 0 and 4 use the 20-cycle wait, the others 5. o_init_done and o_ready rise together after the last wait; o_lcd_rw=0 throughout.
2. After init, single write rs=1 data=0x41 -> o_ready=0 on the next cycle. EN rises 2 cycles after the accept edge and stays high 3 cycles. RS=1 and data=0x41 are stable throughout. o_ready returns 12 cycles after the accept edge.
3. Write rs=0 data=0x01 -> 20-cycle wait, o_ready back 27 cycles after accept. Repeat with rs=1 data=0x01 -> 5-cycle wait (a data byte is not a clear).
4. i_valid held high with changing data while busy -> exactly one accept per IDLE window. Two queued bytes 0x48, 0x49 produce two EN pulses in order; mid-busy data changes do not alter the pins.
5. Assert i_reset during PULSE -> o_lcd_en=0 and o_init_done=0 in the same cycle, without waiting for a clock edge. After release the init sequence restarts from 0x38.
6. i_valid=1 throughout init -> no accept before o_init_done. The pending request is accepted on the first IDLE cycle.
